// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: datapath widths and the writeback-source encoding.
package mem_wb_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_e;

  // Link beats load, load beats ALU result.
  function automatic wb_sel_e wbSelect(input logic jar, input logic memToReg);
    if (jar)      return WB_PC;
    if (memToReg) return WB_MEM;
    return WB_ALU;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-MEM inputs and MEM/WB outputs of the memory stage, including the forwarding taps.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic                  MenWrtoMe;
  logic                  MentoRegtoMe;
  logic                  RegWrtoMe;
  logic                  jartoMe;
  logic [REG_ADDR_W-1:0] rwtoMe;
  logic [WORD_W-1:0]     ALUout;
  logic [WORD_W-1:0]     busBtoMe;
  logic [WORD_W-1:0]     pcNewtoMe;
  logic [WORD_W-1:0]     instoMe;

  logic                  RegWrtoWb;
  logic [REG_ADDR_W-1:0] rwtoWb;
  logic [WORD_W-1:0]     busWtoWb;
  logic [WORD_W-1:0]     instoWb;
  logic [WORD_W-1:0]     meFwdData;
  logic                  meFwdValid;
  logic                  misalignFlag;
  logic [WORD_W-1:0]     storeCount;

  modport master (
    output MenWrtoMe, MentoRegtoMe, RegWrtoMe, jartoMe, rwtoMe,
           ALUout, busBtoMe, pcNewtoMe, instoMe,
    input  RegWrtoWb, rwtoWb, busWtoWb, instoWb, meFwdData, meFwdValid,
           misalignFlag, storeCount
  );

  modport slave (
    input  MenWrtoMe, MentoRegtoMe, RegWrtoMe, jartoMe, rwtoMe,
           ALUout, busBtoMe, pcNewtoMe, instoMe,
    output RegWrtoWb, rwtoWb, busWtoWb, instoWb, meFwdData, meFwdValid,
           misalignFlag, storeCount
  );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: synchronous write on the falling edge, asynchronous read.
module data_mem
   import mem_wb_stage_pkg::*;
#(
   parameter int    DEPTH_LOG2 = 10,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [WORD_W-1:0]     wdata_i,
   output logic [WORD_W-1:0]     rdata_o
);

   logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

   // Store the write data into the addressed word on the falling edge when enabled.
   always_ff @(negedge clk) begin
      if (we_i) mem[addr_i] <= wdata_i;
   end

   assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB register: data memory access, writeback select, EX forwarding, store stats.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  logic [DEPTH_LOG2-1:0] memIndex;
  logic                  misaligned;
  logic                  storeEn;
  logic [WORD_W-1:0]     rdata;
  logic [WORD_W-1:0]     fwdData;

  logic                  regWr_q,     regWr_d;
  logic [REG_ADDR_W-1:0] rw_q,        rw_d;
  logic [WORD_W-1:0]     busW_q,      busW_d;
  logic [WORD_W-1:0]     ins_q,       ins_d;
  logic                  misalign_q,  misalign_d;
  logic [WORD_W-1:0]     storeCount_q, storeCount_d;

  assign memIndex   = bus.ALUout[DEPTH_LOG2+1:2];
  assign misaligned = |bus.ALUout[1:0];
  // Reset must also suppress the memory write, not just the counters.
  assign storeEn    = !rst && bus.MenWrtoMe && !misaligned;

  data_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) uDataMem (
    .clk    (clk),
    .we_i   (storeEn),
    .addr_i (memIndex),
    .wdata_i(bus.busBtoMe),
    .rdata_o(rdata)
  );

  always_comb begin
    fwdData = bus.ALUout;
    case (wbSelect(bus.jartoMe, bus.MentoRegtoMe))
      WB_PC:   fwdData = bus.pcNewtoMe;
      WB_MEM:  fwdData = rdata;
      default: fwdData = bus.ALUout;
    endcase
  end

  always_comb begin
    regWr_d      = bus.RegWrtoMe;
    rw_d         = bus.rwtoMe;
    busW_d       = fwdData;
    ins_d        = bus.instoMe;
    misalign_d   = misalign_q | ((bus.MenWrtoMe | bus.MentoRegtoMe) & misaligned);
    storeCount_d = storeEn ? storeCount_q + 32'd1 : storeCount_q;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      regWr_q      <= 1'b0;
      rw_q         <= '0;
      busW_q       <= '0;
      ins_q        <= '0;
      misalign_q   <= 1'b0;
      storeCount_q <= '0;
    end else begin
      regWr_q      <= regWr_d;
      rw_q         <= rw_d;
      busW_q       <= busW_d;
      ins_q        <= ins_d;
      misalign_q   <= misalign_d;
      storeCount_q <= storeCount_d;
    end
  end

  assign bus.RegWrtoWb    = regWr_q;
  assign bus.rwtoWb       = rw_q;
  assign bus.busWtoWb     = busW_q;
  assign bus.instoWb      = ins_q;
  assign bus.meFwdData    = fwdData;
  assign bus.meFwdValid   = bus.RegWrtoMe && (bus.rwtoMe != '0);
  assign bus.misalignFlag = misalign_q;
  assign bus.storeCount   = storeCount_q;

endmodule
